ram_port_ctrl: RTL

RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

---
 rtl/ram_port_ctrl_if.sv | 35 +++
 rtl/ram_port_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ram_port_ctrl_if.sv
// ram_port_ctrl_if
//   Request/response bus between a requester and the RAM port controller.
//   Signals:
//     req_valid  requester -> ctrl  request present
//     req_ready  ctrl -> requester  controller can accept a request
//     req_wr     requester -> ctrl  1 = write, 0 = read
//     req_addr   requester -> ctrl  request address (AW bits)
//     req_wdata  requester -> ctrl  write data (DW bits)
//     rsp_valid  ctrl -> requester  read data available
//     rsp_ready  requester -> ctrl  requester takes the response
//     rsp_data   ctrl -> requester  read data (DW bits)
//   Modports: master = requester side, slave = controller side.
interface ram_port_ctrl_if #(
  parameter int AW = 7,
  parameter int DW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl
//   Single-port RAM controller. Accepts one read or write request at a time
//   from the request bus, drives the RAM for exactly one cycle, and returns
//   read data through a valid/ready response held until taken. Keeps
//   saturating counts of completed writes and reads.
//   Ports:
//     clk        single clock, all state on posedge
//     rst        synchronous active-high reset
//     bus        request/response bus (slave side)
//     ram_enb    RAM write enable (0 selects a read cycle)
//     ram_addr   RAM address
//     ram_wdata  RAM write data
//     ram_rdata  RAM read data, updated by the RAM on negedge while ram_enb=0
//     wr_cnt     saturating count of completed writes
//     rd_cnt     saturating count of completed reads
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   WR    | ram_enb high for one cycle, RAM commits at the closing posedge
//   RD    | read cycle, RAM presents data at mid-cycle negedge
//   RESP  | rsp_valid held with captured data until rsp_ready
module ram_port_ctrl #(
  parameter int AW = 7,
  parameter int DW = 4
) (
  input  logic           clk,
  input  logic           rst,
  ram_port_ctrl_if.slave bus,
  output logic           ram_enb,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_wdata,
  input  logic [DW-1:0]  ram_rdata,
  output logic [7:0]     wr_cnt,
  output logic [7:0]     rd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_data_q;
  logic          ram_enb_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic [7:0]    wr_cnt_q;
  logic [7:0]    rd_cnt_q;
  logic [7:0]    wr_cnt_d;
  logic [7:0]    rd_cnt_d;

  // Saturating increments: hold at 255 instead of wrapping.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 8'd1;
    if (rd_cnt_q != 8'hFF) rd_cnt_d = rd_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ram_enb_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // req_ready is low for the first IDLE cycle after reset, so the
          // acceptance test must use the registered ready, not the state.
          if (req_ready_q && bus.req_valid) begin
            req_ready_q <= 1'b0;
            ram_addr_q  <= bus.req_addr;
            if (bus.req_wr) begin
              ram_enb_q   <= 1'b1;
              ram_wdata_q <= bus.req_wdata;
              state_q     <= S_WR;
            end else begin
              ram_enb_q <= 1'b0;
              state_q   <= S_RD;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WR: begin
          ram_enb_q   <= 1'b0;
          wr_cnt_q    <= wr_cnt_d;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_RD: begin
          rsp_data_q  <= ram_rdata;
          rsp_valid_q <= 1'b1;
          rd_cnt_q    <= rd_cnt_d;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          ram_enb_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign ram_enb       = ram_enb_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign wr_cnt        = wr_cnt_q;
  assign rd_cnt        = rd_cnt_q;

endmodule
